regfile_seq: RTL and testbench

Bulk-access sequencer that sits on the initiator side of the 32×32 register file's ports (raddr/rdata read port, we/waddr/wdata write port). It accepts a load or dump command, then either streams words from a valid/ready input into consecutive registers, or reads consecutive registers out to a valid/ready output stream. It is used for register-file initialisation and state dump in place of file-based preload, with an external mux granting it the register-file ports while `busy` is high.

---
 rtl/regseq_pkg.sv | 24 ++
 rtl/regseq_out_buf.sv | 45 ++++
 rtl/regfile_seq.sv | 143 ++++++++++++++
 tb/tb_regfile_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regseq_pkg.sv
// Shared types and constants for the regfile_seq bulk load/dump sequencer.
// Build option: REGSEQ_SKIP_R0_EN makes every visited span skip register 0.
package regseq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDump,
        StDone
    } state_e;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;

`ifdef REGSEQ_SKIP_R0_EN
    localparam bit SKIP_R0 = 1'b1;
`else
    localparam bit SKIP_R0 = 1'b0;
`endif

endpackage

// File: rtl/regseq_out_buf.sv
// One-entry valid/ready register slice carrying dump data and the last flag.
module regseq_out_buf
    import regseq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    logic              valid_q;
    logic              last_q;
    logic [DATA_W-1:0] data_q;

    // Accept a new word when empty or when the held word leaves this cycle.
    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            last_q  <= in_last_i;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/regfile_seq.sv
// Bulk load/dump sequencer that owns the register-file ports while busy_o is high.
// Build option: REGSEQ_SKIP_R0_EN skips address 0 (no input word, no write, no beat).
module regfile_seq
    import regseq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_base_i,
    input  logic [ADDR_W:0]   cmd_count_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o
);

    localparam int unsigned     CntW    = ADDR_W + 1;
    localparam logic [CntW-1:0] FullCnt = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CntW-1:0]   rem_q;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    logic [CntW-1:0] cmd_cnt;
    logic            only_r0;
    logic            skip_addr;
    logic            last_visit;
    logic            in_fire;
    logic            buf_load;
    logic            buf_in_ready;
    logic            buf_fire;
    logic            beat_done;

    always_comb begin
        cmd_cnt    = (cmd_count_i == '0) ? FullCnt : cmd_count_i;
        only_r0    = SKIP_R0 && (cmd_base_i == '0) && (cmd_cnt == CntW'(1));
        skip_addr  = SKIP_R0 && (addr_q == '0) && (rem_q != '0);
        // Final visit, looking past a trailing address 0 that will be skipped.
        last_visit = (rem_q == CntW'(1)) ||
                     (SKIP_R0 && (rem_q == CntW'(2)) && (addr_q == '1));
        in_ready_o = (state_q == StLoad) && !skip_addr && (rem_q != '0);
        in_fire    = in_valid_i && in_ready_o;
        buf_load   = (state_q == StDump) && !skip_addr && (rem_q != '0);
        buf_fire   = buf_load && buf_in_ready;
        beat_done  = out_valid_o && out_ready_i && out_last_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rem_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        addr_q <= cmd_base_i;
                        rem_q  <= cmd_cnt;
                        if (only_r0) begin
                            state_q <= StDone;
                        end else if (cmd_op_i == OP_DUMP) begin
                            state_q <= StDump;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (in_fire) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= addr_q;
                        rf_wdata_q <= in_data_i;
                        addr_q     <= addr_q + ADDR_W'(1);
                        rem_q      <= rem_q - CntW'(1);
                        if (last_visit) begin
                            state_q <= StDone;
                        end
                    end else if (skip_addr) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - CntW'(1);
                    end
                end
                StDump: begin
                    if (buf_fire || skip_addr) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - CntW'(1);
                    end
                    if (beat_done) begin
                        state_q <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    regseq_out_buf #(
        .DATA_W(DATA_W)
    ) u_out_buf (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (buf_load),
        .in_ready_o (buf_in_ready),
        .in_data_i  (rf_rdata_i),
        .in_last_i  (last_visit),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o)
    );

    assign cmd_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign rf_raddr_o  = addr_q;
    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq: vector table plus write/beat scoreboards.
module tb_regfile_seq;
    import regseq_pkg::*;

`ifdef REGSEQ_SKIP_R0_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    typedef struct {
        logic       op;
        logic [4:0] base;
        logic [5:0] count;
        logic       gap;
        logic [3:0] pat;
        int         n;
    } vec_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [4:0]  cmd_base;
    logic [5:0]  cmd_count;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic        busy, done;
    logic [4:0]  rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, rf_wdata;
    logic        rf_we;

    logic [31:0] rf_mem   [32] = '{default: '0};
    logic [31:0] model_rf [32] = '{default: '0};

    wr_t   exp_wr[$];
    beat_t exp_beats[$];
    int    span[$];
    vec_t  vecs[8];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int beat_cnt = 0;
    int last_beat_cyc = 0;
    logic        stall_q = 1'b0;
    logic        stall_last;
    logic [31:0] stall_data;

    regfile_seq dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i   (cmd_op),
        .cmd_base_i (cmd_base),
        .cmd_count_i(cmd_count),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .busy_o     (busy),
        .done_o     (done),
        .rf_raddr_o (rf_raddr),
        .rf_rdata_i (rf_rdata),
        .rf_we_o    (rf_we),
        .rf_waddr_o (rf_waddr),
        .rf_wdata_o (rf_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file environment: negedge write, combinational read.
    always @(negedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    assign rf_rdata = rf_mem[rf_raddr];

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (rf_we) begin
                wr_t e;
                wr_cnt++;
                chk(exp_wr.size() != 0, "unexpected_write", 32'(rf_waddr), 0);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk(rf_waddr == e.addr, "rf_waddr", 32'(rf_waddr), 32'(e.addr));
                    chk(rf_wdata == e.data, "rf_wdata", rf_wdata, e.data);
                end
            end
            if (stall_q) begin
                chk(out_valid, "stall_valid", 32'(out_valid), 1);
                chk(out_data == stall_data, "stall_data", out_data, stall_data);
                chk(out_last == stall_last, "stall_last", 32'(out_last), 32'(stall_last));
            end
            if (out_valid && out_ready) begin
                beat_t b;
                beat_cnt++;
                chk(exp_beats.size() != 0, "unexpected_beat", out_data, 0);
                if (exp_beats.size() != 0) begin
                    b = exp_beats.pop_front();
                    chk(out_data == b.data, "out_data", out_data, b.data);
                    chk(out_last == b.last, "out_last", 32'(out_last), 32'(b.last));
                end
                if (out_last) last_beat_cyc = cyc;
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
        end
    end

    function automatic void build_span(input logic [4:0] base, input logic [5:0] count);
        int n = (count == 0) ? 32 : int'(count);
        span.delete();
        for (int i = 0; i < n; i++) begin
            int a = (int'(base) + i) % 32;
            if (!(Skip && a == 0)) span.push_back(a);
        end
    endfunction

    task automatic issue_cmd(input logic op, input logic [4:0] base, input logic [5:0] count);
        @(posedge clk); #1;
        for (int t = 0; t < 50 && !cmd_ready; t++) begin
            @(posedge clk); #1;
        end
        chk(cmd_ready, "cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        cmd_count = count;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_load(input vec_t v, input bit seq_data);
        int          start_wr = wr_cnt;
        logic        got;
        logic [31:0] d;
        build_span(v.base, v.count);
        issue_cmd(OP_LOAD, v.base, v.count);
        for (int k = 0; k < span.size(); k++) begin
            d = seq_data ? 32'h1000 + 32'(span[k]) : $urandom;
            in_valid = 1'b1;
            in_data  = d;
            got      = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (in_ready) begin
                    got = 1'b1;
                    exp_wr.push_back('{addr: 5'(span[k]), data: d});
                    model_rf[span[k]] = d;
                end
                @(posedge clk); #1;
                if (got) break;
            end
            chk(got, "load_handshake", 32'(got), 1);
            in_valid = 1'b0;
            if (v.gap && k + 1 < span.size()) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_DUMP;
                cmd_base  = 5'd0;
                cmd_count = 6'd1;
                chk(!cmd_ready, "cmd_ignored_in_load", 32'(cmd_ready), 0);
                @(posedge clk); #1;
                cmd_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk(done, "load_done_pulse", 32'(done), 1);
        @(posedge clk);
        @(negedge clk);
        chk(cmd_ready, "load_idle_ready", 32'(cmd_ready), 1);
        chk(!done, "load_done_one_cycle", 32'(done), 0);
        chk(exp_wr.size() == 0, "load_writes_missing", 32'(exp_wr.size()), 0);
        chk(wr_cnt - start_wr == v.n, "load_write_count", 32'(wr_cnt - start_wr), 32'(v.n));
    endtask

    task automatic run_dump(input vec_t v);
        int   start_b = beat_cnt;
        int   first_t = (Skip && v.base == 0) ? 2 : 1;
        logic seen = 1'b0;
        build_span(v.base, v.count);
        for (int k = 0; k < span.size(); k++)
            exp_beats.push_back('{data: model_rf[span[k]], last: (k == span.size() - 1)});
        issue_cmd(OP_DUMP, v.base, v.count);
        for (int t = 0; t < 300; t++) begin
            out_ready = v.pat[2'(t)];
            @(negedge clk);
            if (t < first_t) chk(!out_valid, "dump_early_valid", 32'(out_valid), 0);
            if (t == first_t) chk(out_valid, "dump_first_beat", 32'(out_valid), 1);
            if (done) begin
                seen = 1'b1;
                chk(cyc == last_beat_cyc + 1, "dump_done_timing", 32'(cyc),
                    32'(last_beat_cyc + 1));
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk(seen, "dump_done_seen", 32'(seen), 1);
        chk(exp_beats.size() == 0, "dump_beats_missing", 32'(exp_beats.size()), 0);
        chk(beat_cnt - start_b == v.n, "dump_beat_count", 32'(beat_cnt - start_b), 32'(v.n));
    endtask

    task automatic reset_mid_dump();
        int start_b = beat_cnt;
        build_span(5'd0, 6'd32);
        for (int k = 0; k < span.size(); k++)
            exp_beats.push_back('{data: model_rf[span[k]], last: (k == span.size() - 1)});
        issue_cmd(OP_DUMP, 5'd0, 6'd32);
        out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (beat_cnt - start_b >= 2) break;
        end
        chk(beat_cnt - start_b >= 2, "rst_two_beats", 32'(beat_cnt - start_b), 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk(!out_valid, "rst_out_valid", 32'(out_valid), 0);
        chk(!out_last, "rst_out_last", 32'(out_last), 0);
        chk(!busy, "rst_busy", 32'(busy), 0);
        chk(!rf_we, "rst_rf_we", 32'(rf_we), 0);
        chk(!done, "rst_done", 32'(done), 0);
        chk(cmd_ready, "rst_cmd_ready", 32'(cmd_ready), 1);
        exp_beats.delete();
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk(cmd_ready, "rst_release_ready", 32'(cmd_ready), 1);
        chk(!busy, "rst_release_busy", 32'(busy), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        //          op       base   count  gap   pat      n
        vecs[0] = '{OP_LOAD, 5'd0,  6'd0,  1'b0, 4'b1111, Skip ? 31 : 32};
        vecs[1] = '{OP_DUMP, 5'd0,  6'd32, 1'b0, 4'b1111, Skip ? 31 : 32};
        vecs[2] = '{OP_DUMP, 5'd30, 6'd4,  1'b0, 4'b1001, Skip ? 3 : 4};
        vecs[3] = '{OP_LOAD, 5'd5,  6'd3,  1'b1, 4'b1111, 3};
        vecs[4] = '{OP_LOAD, 5'd31, 6'd3,  1'b0, 4'b1111, Skip ? 2 : 3};
        vecs[5] = '{OP_DUMP, 5'd29, 6'd5,  1'b0, 4'b0011, Skip ? 4 : 5};
        vecs[6] = '{OP_LOAD, 5'd10, 6'd1,  1'b0, 4'b1111, 1};
        vecs[7] = '{OP_DUMP, 5'd10, 6'd1,  1'b0, 4'b0110, 1};

        repeat (2) @(posedge clk);
        #1;
        chk(cmd_ready, "reset_cmd_ready", 32'(cmd_ready), 1);
        chk(!busy, "reset_busy", 32'(busy), 0);
        chk(!in_ready, "reset_in_ready", 32'(in_ready), 0);
        chk(!out_valid, "reset_out_valid", 32'(out_valid), 0);
        chk(!rf_we, "reset_rf_we", 32'(rf_we), 0);
        chk(!done, "reset_done", 32'(done), 0);
        chk(rf_raddr == 0 && rf_waddr == 0, "reset_addrs", 32'({rf_raddr, rf_waddr}), 0);
        chk(rf_wdata == 0 && out_data == 0, "reset_data", rf_wdata | out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk(cmd_ready && !busy, "release_idle", 32'({cmd_ready, busy}), 32'h2);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].op == OP_LOAD) run_load(vecs[i], i == 0);
            else run_dump(vecs[i]);
        end

        reset_mid_dump();
        run_load(vecs[6], 1'b0);
        run_dump(vecs[7]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
